// File: rtl/log2_seq_if.sv
// log2_seq_if
// Bundles the operand request and result handshake of the sequential log2 unit.
//   in_valid  / in_ready  : operand request and the unit's willingness to take it
//   num       [IN_W]      : unsigned operand
//   ceil_mode             : 1 = integer ceil(log2), 0 = floor(log2) with fraction
//   out_valid / out_ready : result available and consumer acceptance
//   log2_q    [OUT_W]     : unsigned fixed-point result
//   err                   : the operand was zero
// The master modport is the requester; the slave modport is the log2 unit.
interface log2_seq_if #(
    parameter int IN_W  = 10,
    parameter int OUT_W = 12
) ();
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  num;
    logic             ceil_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] log2_q;
    logic             err;

    modport master (
        output in_valid,
        output num,
        output ceil_mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  log2_q,
        input  err
    );

    modport slave (
        input  in_valid,
        input  num,
        input  ceil_mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output log2_q,
        output err
    );
endinterface

// File: rtl/log2_seq.sv
// log2_seq
// Sequential base-2 logarithm. An accepted operand is normalised by left
// shifts (one per cycle) to find its integer log2. In floor mode the fraction
// is then produced one bit per cycle by repeated squaring of the normalised
// mantissa. In ceil mode the integer part is rounded up unless the operand is
// an exact power of two.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : log2_seq_if.slave (operand request, result handshake, log2_q, err)
// Parameters:
//   IN_W   : operand width (2..32)
//   FRAC_W : fractional result bits (1..OUT_W-6)
//   OUT_W  : result width; integer field log2_q[OUT_W-1:FRAC_W]
// Configuration:
//   LOG2_FRAC_EN : when defined, the FRAC state and squaring datapath are built.
//                  When undefined, the fraction field is always zero and both
//                  modes finish right after normalisation.
module log2_seq #(
    parameter int IN_W   = 10,
    parameter int FRAC_W = 4,
    parameter int OUT_W  = 12
) (
    input logic       clk,
    input logic       rst,
    log2_seq_if.slave bus
);

    localparam int INT_W = OUT_W - FRAC_W;
    localparam int CNT_W = $clog2(IN_W + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
`ifdef LOG2_FRAC_EN
    localparam logic [1:0] FRAC = 2'd2;
`endif
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [IN_W-1:0]  mant;
    logic [CNT_W-1:0] cnt;
    logic             ceil_r;
    logic             zero_r;
    logic             out_valid_r;
    logic [OUT_W-1:0] q_r;
    logic             err_r;

    logic             msb_only;
    logic [INT_W-1:0] int_part;
    logic [FRAC_W-1:0] frac_field;
    logic [OUT_W-1:0] result;

`ifdef LOG2_FRAC_EN
    localparam int FCNT_W = $clog2(FRAC_W + 1);

    logic [FRAC_W-1:0]  frac_r;
    logic [FCNT_W-1:0]  fcnt;
    logic [2*IN_W-1:0]  sq;
    logic               sq_ge2;
    logic [IN_W-1:0]    sq_next;
    logic               sq_unused;

    // Mantissa is Q1.(IN_W-1) in [1,2), so its square is Q2.(2*IN_W-2) in
    // [1,4). Dropping the low IN_W-1 bits truncates it back to Q2.(IN_W-1);
    // the top bit then says whether the square reached 2, in which case the
    // halved (truncated) value becomes the next mantissa.
    assign sq        = {{IN_W{1'b0}}, mant} * {{IN_W{1'b0}}, mant};
    assign sq_ge2    = sq[2*IN_W-1];
    assign sq_next   = sq_ge2 ? sq[2*IN_W-1:IN_W] : sq[2*IN_W-2:IN_W-1];
    assign sq_unused = ^sq[IN_W-2:0];
    assign frac_field = frac_r;
`else
    assign frac_field = '0;
`endif

    // A normalised mantissa with only its MSB set means the operand was an
    // exact power of two, so ceil and floor agree.
    assign msb_only = (mant == {1'b1, {(IN_W-1){1'b0}}});

    // Integer part is IN_W-1 minus the number of normalising shifts, rounded
    // up in ceil mode for non-powers of two. Wider values wrap into the field.
    assign int_part = INT_W'(IN_W - 1) - INT_W'(cnt) + INT_W'(ceil_r && !msb_only);

    // A zero operand reports err with an all-zero result.
    assign result = zero_r ? '0 : {int_part, frac_field};

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.log2_q    = q_r;
    assign bus.err       = err_r;

    // Control FSM and datapath registers. DONE spends its first cycle
    // latching the result and raising out_valid, then holds everything until
    // the consumer accepts; the unit only re-enters IDLE the cycle after.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mant        <= '0;
            cnt         <= '0;
            ceil_r      <= 1'b0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
            q_r         <= '0;
            err_r       <= 1'b0;
`ifdef LOG2_FRAC_EN
            frac_r      <= '0;
            fcnt        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mant   <= bus.num;
                        ceil_r <= bus.ceil_mode;
                        cnt    <= '0;
                        zero_r <= 1'b0;
`ifdef LOG2_FRAC_EN
                        frac_r <= '0;
                        fcnt   <= '0;
`endif
                        state  <= NORM;
                    end
                end
                NORM: begin
                    if (mant == '0) begin
                        zero_r <= 1'b1;
                        state  <= DONE;
                    end else if (!mant[IN_W-1]) begin
                        mant <= mant << 1;
                        cnt  <= cnt + 1'b1;
                    end else begin
`ifdef LOG2_FRAC_EN
                        fcnt  <= '0;
                        state <= ceil_r ? DONE : FRAC;
`else
                        state <= DONE;
`endif
                    end
                end
`ifdef LOG2_FRAC_EN
                FRAC: begin
                    mant   <= sq_next;
                    frac_r <= FRAC_W'({frac_r, sq_ge2});
                    fcnt   <= fcnt + 1'b1;
                    if (fcnt == FCNT_W'(FRAC_W - 1)) begin
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        q_r         <= result;
                        err_r       <= zero_r;
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log2_seq.sv
// tb_log2_seq
// Scoreboard bench for log2_seq. The driver pushes the expected result,
// error flag and latency of every accepted operand; an independent monitor
// compares whatever the unit presents against the head of the queue, checks
// that results stay stable while stalled and that the unit idles right after
// each handshake. Expected values come from a plain-arithmetic model.
module tb_log2_seq;

    localparam int IN_W   = 10;
    localparam int FRAC_W = 4;
    localparam int OUT_W  = 12;
`ifdef LOG2_FRAC_EN
    localparam bit FRAC_ON = 1'b1;
`else
    localparam bit FRAC_ON = 1'b0;
`endif

    typedef struct {
        int q;
        bit err;
        int lat;
        int acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t sb[$];
    int   cyc         = 0;
    int   ncompared   = 0;
    int   nmismatched = 0;
    int   stallcycles = 0;
    bit   randready   = 1'b0;
    bit   seen        = 1'b0;
    bit   post_pop    = 1'b0;

    log2_seq_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    log2_seq #(.IN_W(IN_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock and edge counter used for latency measurement.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Compare one value and keep the running tallies.
    task automatic checkOutput(input string name, input int actual, input int expected);
        ncompared++;
        if (actual !== expected) begin
            nmismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Reference: integer log2 from the highest set bit, fraction by repeated
    // squaring of num/2^p with truncation, latency from shift and bit counts.
    function automatic exp_t model(input int n, input bit c);
        exp_t   e;
        int     p;
        int     l;
        int     fr;
        longint m;
        e.q   = 0;
        e.err = 1'b0;
        e.acc = 0;
        if (n == 0) begin
            e.err = 1'b1;
            e.lat = 2;
            return e;
        end
        p = 0;
        for (int i = 0; i < IN_W; i++) begin
            if (((n >> i) & 1) == 1) p = i;
        end
        l = IN_W - 1 - p;
        if (c) begin
            e.q   = (p + ((n != (1 << p)) ? 1 : 0)) << FRAC_W;
            e.lat = 2 + l;
        end else if (!FRAC_ON) begin
            e.q   = p << FRAC_W;
            e.lat = 2 + l;
        end else begin
            m  = longint'(n) << l;
            fr = 0;
            for (int k = 0; k < FRAC_W; k++) begin
                m  = (m * m) >> (IN_W - 1);
                fr = fr * 2;
                if (m >= (longint'(1) << IN_W)) begin
                    fr = fr + 1;
                    m  = m >> 1;
                end
            end
            e.q   = (p << FRAC_W) + fr;
            e.lat = 2 + l + FRAC_W;
        end
        return e;
    endfunction

    // Present one operand, hold it until the unit takes it, record expectation.
    task automatic applyStimulus(input int n, input bit c);
        exp_t e;
        int   guard;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.num       = IN_W'(n);
        bus.ceil_mode = c;
        guard = 0;
        while (!bus.in_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            checkOutput("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e     = model(n, c);
        e.acc = cyc;
        sb.push_back(e);
        #1 bus.in_valid = 1'b0;
    endtask

    // Wait for every outstanding result to be consumed, within a bound.
    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            checkOutput("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Consumer: forced stall window after a result appears, else random or always-ready.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bus.out_valid && stallcycles > 0) begin
                bus.out_ready = 1'b0;
                stallcycles--;
            end else if (randready) begin
                bus.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // Monitor: compare presented results against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen     = 1'b0;
            post_pop = 1'b0;
        end else begin
            if (post_pop) begin
                checkOutput("idle_after_hs_in_ready", int'(bus.in_ready), 1);
                checkOutput("idle_after_hs_out_valid", int'(bus.out_valid), 0);
                post_pop = 1'b0;
            end
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        seen = 1'b1;
                        checkOutput("latency", (cyc - 1) - e.acc, e.lat);
                    end
                    checkOutput("log2_q", int'(bus.log2_q), e.q);
                    checkOutput("err", int'(bus.err), int'(e.err));
                    checkOutput("busy_in_ready", int'(bus.in_ready), 0);
                    if (bus.out_ready) begin
                        void'(sb.pop_front());
                        seen     = 1'b0;
                        post_pop = 1'b1;
                    end
                end
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence: reset, directed corner cases, stall, mid-op reset, random.
    initial begin
        int n;
        int sel;
        bus.in_valid  = 1'b0;
        bus.num       = '0;
        bus.ceil_mode = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", int'(bus.in_ready), 1);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_log2_q", int'(bus.log2_q), 0);
        checkOutput("rst_err", int'(bus.err), 0);
        rst = 1'b0;

        applyStimulus(10, 1'b0);
        applyStimulus(10, 1'b1);
        applyStimulus(512, 1'b1);
        applyStimulus(1, 1'b0);
        applyStimulus(0, 1'b0);
        applyStimulus(0, 1'b1);
        applyStimulus(1, 1'b1);
        applyStimulus(512, 1'b0);
        drain();

        stallcycles = 5;
        applyStimulus(1023, 1'b0);
        drain();

        applyStimulus(10, 1'b0);
        repeat (FRAC_ON ? 8 : 3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midop_rst_in_ready", int'(bus.in_ready), 1);
        checkOutput("midop_rst_out_valid", int'(bus.out_valid), 0);
        applyStimulus(512, 1'b0);
        drain();

        randready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 7);
            if (sel == 0)      n = 0;
            else if (sel == 1) n = 1 << $urandom_range(0, IN_W - 1);
            else if (sel == 2) n = (1 << $urandom_range(1, IN_W - 1)) - 1;
            else               n = $urandom_range(0, (1 << IN_W) - 1);
            applyStimulus(n, 1'($urandom_range(0, 1)));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncompared, nmismatched);
        $finish;
    end

endmodule
